// File: rtl/loba_div_16_4.sv
// Approximate 16-bit unsigned divider: both operands are reduced to a 4-bit leading-one
// segment, the segments are divided bit-serially, and the quotient is rescaled by the exponent gap.
module loba_div_16_4 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] Q,
    output logic        dz,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        DIV,
        SHIFT,
        DONE
    } state_t;

    state_t      state_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  ka_q;
    logic [3:0]  kb_q;
    logic [3:0]  bh_q;
    logic [3:0]  cnt_q;
    logic [3:0]  rem_q;
    logic [14:0] num_q;
    logic [11:0] quo_q;
    logic [15:0] q_q;
    logic        dz_q;
    logic        out_valid_q;
    logic        in_ready_q;

    logic [3:0]  ka_d;
    logic [3:0]  kb_d;
    logic [3:0]  ah_d;
    logic [3:0]  bh_d;
    logic [4:0]  rem_shift_d;
    logic        fits_d;
    logic [3:0]  rem_d;
    logic signed [5:0] s_d;
    logic [5:0]  s_neg_d;
    logic [15:0] q_ext_d;
    logic [15:0] q_shift_d;

    function automatic logic [3:0] lead_one(input logic [15:0] x);
        logic [3:0] k;
        k = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (x[i]) k = 4'(i);
        end
        return k;
    endfunction

    // Left-justifying on the leading one gives the zero padding for short operands for free.
    function automatic logic [3:0] segment(input logic [15:0] x, input logic [3:0] k);
        return 4'((x << (4'd15 - k)) >> 12);
    endfunction

    always_comb begin
        ka_d = lead_one(a_q);
        kb_d = lead_one(b_q);
        ah_d = segment(a_q, ka_d);
        bh_d = segment(b_q, kb_d);

        // The partial remainder stays below the divisor, so the 4-bit wrapped difference is exact.
        rem_shift_d = {rem_q, num_q[14]};
        fits_d      = rem_shift_d[4] | (rem_shift_d[3:0] >= bh_q);
        rem_d       = fits_d ? (rem_shift_d[3:0] - bh_q) : rem_shift_d[3:0];

        s_d       = $signed({2'b00, ka_q}) - $signed({2'b00, kb_q}) - 6'sd11;
        s_neg_d   = 6'(-s_d);
        q_ext_d   = {4'b0000, quo_q};
        q_shift_d = s_d[5] ? (q_ext_d >> s_neg_d) : (q_ext_d << s_d[2:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= 16'd0;
            b_q         <= 16'd0;
            ka_q        <= 4'd0;
            kb_q        <= 4'd0;
            bh_q        <= 4'd0;
            cnt_q       <= 4'd0;
            rem_q       <= 4'd0;
            num_q       <= 15'd0;
            quo_q       <= 12'd0;
            q_q         <= 16'd0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= A;
                        b_q        <= B;
                        in_ready_q <= 1'b0;
                        state_q    <= NORM;
                    end
                end
                NORM: begin
                    if (b_q == 16'd0) begin
                        q_q         <= 16'hFFFF;
                        dz_q        <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (a_q == 16'd0) begin
                        q_q         <= 16'd0;
                        dz_q        <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        ka_q    <= ka_d;
                        kb_q    <= kb_d;
                        bh_q    <= bh_d;
                        num_q   <= {ah_d, 11'd0};
                        rem_q   <= 4'd0;
                        quo_q   <= 12'd0;
                        cnt_q   <= 4'd0;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    num_q <= {num_q[13:0], 1'b0};
                    rem_q <= rem_d;
                    quo_q <= {quo_q[10:0], fits_d};
                    if (cnt_q == 4'd14) begin
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                SHIFT: begin
                    q_q         <= q_shift_d;
                    dz_q        <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign Q         = q_q;
    assign dz        = dz_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/loba_div_16_4.md
LOBA_DIV_16_4 -- requirements
Module: loba_div_16_4

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port A, input, 16 bits: unsigned dividend.
REQ-004 The block SHALL have port B, input, 16 bits: unsigned divisor.
REQ-005 The block SHALL have port in_valid, input, 1 bit: A and B are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-007 The block SHALL have port Q, output, 16 bits: approximate quotient.
REQ-008 The block SHALL have port dz, output, 1 bit: divide-by-zero flag for the current Q.
REQ-009 The block SHALL have port out_valid, output, 1 bit: Q and dz are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts Q.

Function
REQ-011 The block SHALL implement states IDLE, NORM, DIV, SHIFT and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; an accept occurs on a clk edge with in_valid=1 and in_ready=1.
REQ-013 On accept, the block SHALL register A and B and move to NORM; inputs SHALL be ignored outside IDLE.
REQ-014 Leading-one index: kx = position of the most significant 1 of X (0..15).
REQ-015 Segment Xh, 4 bits, with MSB always 1: Xh = X[kx:kx-3] if kx>=3, else X[kx:0] zero-padded on the right to 4 bits; bits below the segment SHALL be discarded.
REQ-016 In NORM, when B=0 the block SHALL set Q=16'hFFFF and dz=1 and go to DONE.
REQ-017 In NORM, when B!=0 and A=0 the block SHALL set Q=0 and dz=0 and go to DONE.
REQ-018 Otherwise, NORM SHALL compute Ah, Bh, ka and kb, load the 15-bit numerator N=Ah<<11, and go to DIV.
REQ-019 DIV SHALL run restoring division of N by Bh, MSB first, one quotient bit per cycle for exactly 15 cycles using a 4-bit counter, producing the 12-bit-significant quotient qs=floor(N/Bh), range 1092..3840.
REQ-020 SHIFT SHALL compute s = ka-kb-11 (signed, range -26..+4).
- s>=0: Q = qs<<s, exact within 16 bits.
- s<0: Q = qs>>(-s), truncating.
- dz=0; next state DONE.
REQ-021 Normal-path latency SHALL be 17 edges: accept edge, then 1 NORM, 15 DIV and 1 SHIFT; out_valid SHALL be high after the 17th edge following the accept edge.
REQ-022 Zero-path latency SHALL be 1 edge after the accept edge.
REQ-023 In DONE, out_valid=1 and Q and dz SHALL hold stable until an edge with out_ready=1, then the block SHALL return to IDLE.
REQ-024 There SHALL be no back-to-back accept: in_ready rises only in the cycle after the out_valid handshake.
REQ-025 An in_valid held high while the block is busy SHALL NOT be consumed until IDLE.
REQ-026 Q and dz SHALL be registered outputs and SHALL NOT change outside NORM and SHIFT transitions.

Reset
REQ-027 On rst=1, regardless of the clock, the block SHALL set state=IDLE, Q=0, dz=0, out_valid=0, the counter to 0 and internal operand registers to 0.
REQ-028 in_ready SHALL be 1 immediately after rst is released.
REQ-029 A reset during any state SHALL abort the operation with no out_valid pulse.

Verification
REQ-030 A=100, B=10 -> Ah=12, Bh=10, qs=2457, s=-8 -> Q=9, dz=0, out_valid exactly 17 edges after the accept.
REQ-031 A=16'hFFFF, B=1 -> Ah=15, Bh=8, qs=3840, s=+4 -> Q=16'hF000.
REQ-032 Check these small and equal cases:
- A=5, B=7 -> Ah=10, Bh=14, qs=1462 -> Q=0.
- A=B=16'h8000 -> Q=1.
REQ-033 A=1234, B=0 -> Q=16'hFFFF, dz=1, 1-edge latency; then A=0, B=3 -> Q=0, dz=0.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> Q, dz and out_valid are stable and in_ready=0; a new in_valid is ignored until the handshake.
REQ-035 Assert rst at DIV cycle 7 -> out_valid=0 and Q=0 at once, in_ready=1 after release, and the next operation A=100, B=10 gives Q=9.
